// File: rtl/serial_conv_scheduler_if.sv
// Bundle of the scheduler's control, loader and output-buffer signals.
// The slave modport is the scheduler; the master modport is its environment.
interface serial_conv_scheduler_if;
    logic        start;
    logic        ldr_done;
    logic [15:0] psum_i;
    logic        ldr_en;
    logic [7:0]  ldr_base;
    logic        out_we;
    logic [5:0]  out_addr;
    logic [15:0] out_data;
    logic        busy;
    logic        done;

    modport master (
        output start, ldr_done, psum_i,
        input  ldr_en, ldr_base, out_we, out_addr, out_data, busy, done
    );

    modport slave (
        input  start, ldr_done, psum_i,
        output ldr_en, ldr_base, out_we, out_addr, out_data, busy, done
    );
endinterface

// File: rtl/serial_conv_scheduler.sv
// Walks every output pixel of a serial-mode 3x3 convolution: runs one loader pass per pixel,
// captures the PE accumulator, applies optional ReLU and writes it to the output buffer.
module serial_conv_scheduler #(
    parameter logic [7:0]  FEAT_BASE = 8'd16,
    parameter int unsigned FEAT_W    = 4,
    parameter int unsigned OUT_ROWS  = 2,
    parameter int unsigned OUT_COLS  = 2,
    parameter logic [5:0]  OUT_BASE  = 6'd48,
    parameter bit          RELU      = 1'b1
) (
    input logic                    clk,
    input logic                    rst,
    serial_conv_scheduler_if.slave sched_io
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRun   = 3'd1;
    localparam logic [2:0] StDrain = 3'd2;
    localparam logic [2:0] StWrite = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic [2:0] ColLast = 3'(OUT_COLS - 1);
    localparam logic [5:0] IdxLast = 6'(OUT_ROWS * OUT_COLS - 1);

    logic [2:0]  state_q, state_d;
    logic [2:0]  r_q, r_d;
    logic [2:0]  c_q, c_d;
    logic [5:0]  idx_q, idx_d;
    logic [15:0] res_q, res_d;
    logic [7:0]  row_off;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        idx_d   = idx_q;
        res_d   = res_q;
        case (state_q)
            StIdle: begin
                if (sched_io.start) begin
                    r_d     = 3'd0;
                    c_d     = 3'd0;
                    idx_d   = 6'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (sched_io.ldr_done) state_d = StDrain;
            end
            StDrain: begin
                // Capture before the loader's delayed PE reset clears the accumulator.
                res_d   = sched_io.psum_i;
                state_d = StWrite;
            end
            StWrite: begin
                if (idx_q == IdxLast) begin
                    state_d = StDone;
                end else begin
                    if (c_q == ColLast) begin
                        c_d = 3'd0;
                        r_d = r_q + 3'd1;
                    end else begin
                        c_d = c_q + 3'd1;
                    end
                    idx_d   = idx_q + 6'd1;
                    state_d = StRun;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            r_q     <= 3'd0;
            c_q     <= 3'd0;
            idx_q   <= 6'd0;
            res_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
        end
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    always_comb begin
        row_off           = 8'(r_q) * 8'(FEAT_W);
        sched_io.ldr_en   = (state_q == StRun);
        sched_io.ldr_base = FEAT_BASE + row_off + 8'(c_q);
        sched_io.out_we   = (state_q == StWrite);
        sched_io.out_addr = OUT_BASE + idx_q;
        sched_io.out_data = (RELU && res_q[15]) ? 16'd0 : res_q;
        sched_io.busy     = (state_q == StRun) || (state_q == StDrain) || (state_q == StWrite);
        sched_io.done     = (state_q == StDone);
    end

endmodule

// File: tb/tb_serial_conv_scheduler.sv
// Bench for serial_conv_scheduler: a loader model feeds psums from a vector table, a scoreboard
// checks every output-buffer write on a RELU=1 and a RELU=0 instance driven in lockstep.
module tb_serial_conv_scheduler;

    localparam int LAT = 18;

    typedef struct {
        logic [15:0] psum;
        logic [7:0]  base;
        logic [5:0]  addr;
        logic [15:0] relu;
        logic [15:0] raw;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_conv_scheduler_if if_a ();
    serial_conv_scheduler_if if_b ();

    assign if_b.start    = if_a.start;
    assign if_b.ldr_done = if_a.ldr_done;
    assign if_b.psum_i   = if_a.psum_i;

    serial_conv_scheduler #(.RELU(1'b1)) dut_a (.clk(clk), .rst(rst), .sched_io(if_a));
    serial_conv_scheduler #(.RELU(1'b0)) dut_b (.clk(clk), .rst(rst), .sched_io(if_b));

    vec_t vecs [8];
    vec_t drv_q [$];
    vec_t sb_q [$];
    vec_t drv_v;
    vec_t sb_v;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int writes = 0;
    int dones = 0;
    int en_cnt = 0;
    int hold_left = 0;
    int hold_len = 1;
    bit idle_pulse = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Loader model: ldr_done after LAT enabled cycles, held hold_len cycles; new psum per pass.
    always @(negedge clk) begin
        if (rst) begin
            en_cnt    = 0;
            hold_left = 0;
        end else begin
            if (if_a.ldr_en) en_cnt++;
            else en_cnt = 0;
            if (en_cnt == 1) begin
                if (drv_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_run: got RUN entry, required none (cycle %0d)", cyc);
                end else begin
                    drv_v = drv_q.pop_front();
                    if_a.psum_i = drv_v.psum;
                    check("ldr_base", 32'(if_a.ldr_base), 32'(drv_v.base));
                    sb_q.push_back(drv_v);
                end
            end
            if (en_cnt == LAT + 1) hold_left = hold_len;
        end
        if_a.ldr_done = (hold_left != 0) || idle_pulse;
        if (hold_left != 0) hold_left--;
    end

    // Scoreboard for output-buffer writes and done pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (if_a.out_we) begin
                writes++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h, required no write", if_a.out_addr);
                end else begin
                    sb_v = sb_q.pop_front();
                    check("out_addr", 32'(if_a.out_addr), 32'(sb_v.addr));
                    check("out_data_relu", 32'(if_a.out_data), 32'(sb_v.relu));
                    check("out_data_raw", 32'(if_b.out_data), 32'(sb_v.raw));
                    check("out_we_b", 32'(if_b.out_we), 32'd1);
                end
            end
            if (if_a.done) begin
                dones++;
                check("busy_at_done", 32'(if_a.busy), 32'd0);
            end
        end
    end

    task automatic run_layer(input int first, input int hold, input bit extra);
        int t0;
        bit got;
        for (int i = 0; i < 4; i++) drv_q.push_back(vecs[first + i]);
        hold_len = hold;
        writes   = 0;
        dones    = 0;
        got      = 1'b0;
        @(negedge clk);
        if_a.start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        if_a.start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (if_a.done) begin
                got = 1'b1;
                break;
            end
            // k=4 lands in the first RUN, k=20 in the first WRITE.
            if_a.start = extra && (k == 4 || k == 20);
            @(negedge clk);
        end
        check("done_seen", 32'(got), 32'd1);
        if (got) check("latency", 32'(cyc - t0), 32'd85);
        if (extra) if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        if (extra) begin
            for (int k = 0; k < 3; k++) begin
                check("idle_busy", 32'(if_a.busy), 32'd0);
                check("idle_ldr_en", 32'(if_a.ldr_en), 32'd0);
                @(negedge clk);
            end
        end
        check("writes", 32'(writes), 32'd4);
        check("dones", 32'(dones), 32'd1);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        vecs[0] = '{16'd5,     8'd16, 6'd48, 16'd5,     16'd5};
        vecs[1] = '{16'hFFFD,  8'd17, 6'd49, 16'd0,     16'hFFFD};
        vecs[2] = '{16'd7,     8'd20, 6'd50, 16'd7,     16'd7};
        vecs[3] = '{16'd100,   8'd21, 6'd51, 16'd100,   16'd100};
        vecs[4] = '{16'h8000,  8'd16, 6'd48, 16'd0,     16'h8000};
        vecs[5] = '{16'h7FFF,  8'd17, 6'd49, 16'h7FFF,  16'h7FFF};
        vecs[6] = '{16'd0,     8'd20, 6'd50, 16'd0,     16'd0};
        vecs[7] = '{16'hFFFF,  8'd21, 6'd51, 16'd0,     16'hFFFF};
        if_a.start = 1'b0;

        // Asynchronous reset mid-cycle, before any clock edge.
        #3 rst = 1'b1;
        #1;
        check("rst_ldr_en", 32'(if_a.ldr_en), 32'd0);
        check("rst_ldr_base", 32'(if_a.ldr_base), 32'd16);
        check("rst_out_we", 32'(if_a.out_we), 32'd0);
        check("rst_out_addr", 32'(if_a.out_addr), 32'd48);
        check("rst_out_data", 32'(if_a.out_data), 32'd0);
        check("rst_busy", 32'(if_a.busy), 32'd0);
        check("rst_done", 32'(if_a.done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("idle_quiet", 32'({if_a.ldr_en, if_a.out_we, if_a.done, if_a.busy}), 32'd0);
        end

        run_layer(0, 1, 1'b0);
        run_layer(4, 1, 1'b0);
        run_layer(0, 1, 1'b1);
        run_layer(4, 3, 1'b0);

        // ldr_done while idle must not move the FSM.
        idle_pulse = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_pulse_quiet", 32'({if_a.ldr_en, if_a.out_we, if_a.busy}), 32'd0);
        end
        idle_pulse = 1'b0;
        @(negedge clk);
        check("idle_pulse_done", 32'(if_a.done), 32'd0);

        // Reset during the third RUN.
        for (int i = 0; i < 4; i++) drv_q.push_back(vecs[i]);
        hold_len = 1;
        dones    = 0;
        @(negedge clk);
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        begin
            bit reached;
            reached = 1'b0;
            for (int k = 0; k < 200; k++) begin
                if (drv_q.size() == 1 && if_a.ldr_en) begin
                    reached = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("third_run_reached", 32'(reached), 32'd1);
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_ldr_en", 32'(if_a.ldr_en), 32'd0);
        check("midrst_busy", 32'(if_a.busy), 32'd0);
        check("midrst_done", 32'(if_a.done), 32'd0);
        check("midrst_ldr_base", 32'(if_a.ldr_base), 32'd16);
        check("midrst_out_addr", 32'(if_a.out_addr), 32'd48);
        drv_q.delete();
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (if_a.ldr_en || if_a.busy) check("post_rst_idle", 32'(if_a.busy), 32'd0);
        end
        check("post_rst_dones", 32'(dones), 32'd0);
        run_layer(0, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
